inst_fetch_ctrl: RTL and testbench

Fetch-side controller for the single-ported instruction ROM. Owns the PC, drives the ROM chip-enable and address, and registers the returned instruction into the IF/ID boundary. Shares the ROM read port between the pipeline fetch and a debug read requester through a bounded-wait arbiter. Sits between the pipeline control unit (stall/flush/branch) and the instruction ROM.

---
 rtl/inst_fetch_ctrl_pkg.sv | 26 ++
 rtl/inst_fetch_ctrl_dbg_arb.sv | 47 ++++
 rtl/inst_fetch_ctrl.sv | 141 ++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: ROM control
// encodings, bus widths, fetch FSM states and a word-alignment helper.
// Optional feature macro used by the fetch files: INST_FETCH_DBG_EN.
`ifndef INST_FETCH_CTRL_DEFINES
`define INST_FETCH_CTRL_DEFINES
`define ChipEnable  1'b1
`define ChipDisable 1'b0
`define ZeroWord    32'h0000_0000
`define InstAddrBus 31:0
`define InstBus     31:0
`endif

package inst_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_DBG  = 2'd2
    } fetchState_e;

    // Force a byte address onto a word boundary.
    function automatic logic [`InstAddrBus] wordAlign(input logic [`InstAddrBus] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_dbg_arb.sv
// Bounded-wait arbiter that lets a debug read steal the ROM port.
// Only instantiated when INST_FETCH_DBG_EN is defined.
module fetch_dbg_arb
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int DBG_WAIT_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic dbg_req_i,
    input  logic stall_i,
    input  logic flush_i,
    output logic grant_o
);

    localparam int CntW = $clog2(DBG_WAIT_MAX + 1);
    localparam logic [CntW-1:0] WaitMax = CntW'(DBG_WAIT_MAX);

    logic [CntW-1:0] waitCnt_q;
    logic [CntW-1:0] waitCnt_d;

    // A stalled pipeline costs nothing to interrupt; otherwise the request
    // must have waited the full budget before a fetch bubble is forced.
    assign grant_o = run_i && dbg_req_i && !flush_i &&
                     (stall_i || (waitCnt_q == WaitMax));

    // Count fetch cycles a request has waited, saturating at the budget.
    always_comb begin
        waitCnt_d = waitCnt_q;
        if (!dbg_req_i || grant_o) begin
            waitCnt_d = '0;
        end else if (run_i && (waitCnt_q != WaitMax)) begin
            waitCnt_d = waitCnt_q + CntW'(1);
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt_q <= '0;
        end else begin
            waitCnt_q <= waitCnt_d;
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch-side controller: owns the PC, drives the instruction ROM and
// registers the returned instruction into the IF/ID boundary.
// Defining INST_FETCH_DBG_EN adds a debug read port sharing the ROM.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          DBG_WAIT_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] rom_inst_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o,
    input  logic        dbg_req_i,
    input  logic [31:0] dbg_addr_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_data_o
);

    fetchState_e        state_q, state_d;
    logic [`InstAddrBus] pc_q, pc_d;
    logic               romCe_q, romCe_d;
    logic [`InstAddrBus] ifPc_q, ifPc_d;
    logic [`InstBus]     ifInst_q, ifInst_d;
    logic               ifValid_q, ifValid_d;
    logic               grant;

`ifdef INST_FETCH_DBG_EN
    logic               dbgAck_q, dbgAck_d;
    logic [`InstBus]     dbgData_q, dbgData_d;

    fetch_dbg_arb #(
        .DBG_WAIT_MAX(DBG_WAIT_MAX)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .run_i    (state_q == FETCH_RUN),
        .dbg_req_i(dbg_req_i),
        .stall_i  (stall_i),
        .flush_i  (flush_i),
        .grant_o  (grant)
    );

    assign dbg_ack_o  = dbgAck_q;
    assign dbg_data_o = dbgData_q;
`else
    logic unusedDbg;

    assign unusedDbg  = ^{dbg_req_i, dbg_addr_i};
    assign grant      = 1'b0;
    assign dbg_ack_o  = 1'b0;
    assign dbg_data_o = `ZeroWord;
`endif

    // Next-state logic: the debug cycle still fetches normally so that a
    // stolen ROM slot costs exactly one IF bubble.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        romCe_d    = `ChipEnable;
        ifPc_d     = ifPc_q;
        ifInst_d   = ifInst_q;
        ifValid_d  = ifValid_q;
        rom_addr_o = pc_q;
`ifdef INST_FETCH_DBG_EN
        dbgAck_d   = grant;
        dbgData_d  = dbgData_q;
`endif
        case (state_q)
            FETCH_IDLE: begin
                state_d = FETCH_RUN;
            end
            FETCH_RUN, FETCH_DBG: begin
                state_d = FETCH_RUN;
                if (flush_i) begin
                    pc_d      = wordAlign(new_pc_i);
                    ifValid_d = 1'b0;
                end else if (grant) begin
                    state_d = FETCH_DBG;
`ifdef INST_FETCH_DBG_EN
                    rom_addr_o = wordAlign(dbg_addr_i);
                    dbgData_d  = rom_inst_i;
`endif
                    if (!stall_i) begin
                        ifValid_d = 1'b0;
                    end
                end else if (!stall_i) begin
                    ifPc_d    = pc_q;
                    ifInst_d  = rom_inst_i;
                    ifValid_d = 1'b1;
                    pc_d      = branch_flag_i ? wordAlign(branch_target_i) : pc_q + 32'd4;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    // State and IF/ID boundary registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH_IDLE;
            pc_q      <= RESET_PC;
            romCe_q   <= `ChipDisable;
            ifPc_q    <= `ZeroWord;
            ifInst_q  <= `ZeroWord;
            ifValid_q <= 1'b0;
`ifdef INST_FETCH_DBG_EN
            dbgAck_q  <= 1'b0;
            dbgData_q <= `ZeroWord;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            romCe_q   <= romCe_d;
            ifPc_q    <= ifPc_d;
            ifInst_q  <= ifInst_d;
            ifValid_q <= ifValid_d;
`ifdef INST_FETCH_DBG_EN
            dbgAck_q  <= dbgAck_d;
            dbgData_q <= dbgData_d;
`endif
        end
    end

    assign rom_ce_o   = romCe_q;
    assign if_pc_o    = ifPc_q;
    assign if_inst_o  = ifInst_q;
    assign if_valid_o = ifValid_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl. ROM word i holds value i.
// Debug sequences are exercised when INST_FETCH_DBG_EN is defined.
module tb_inst_fetch_ctrl;

    localparam int WaitMax = 8;
`ifdef INST_FETCH_DBG_EN
    localparam bit DbgEn = 1'b1;
`else
    localparam bit DbgEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, branchFlag, dbgReq;
    logic [31:0] newPc, branchTarget, dbgAddr;
    logic [31:0] romInst, romAddr, ifPc, ifInst, dbgData;
    logic        romCe, ifValid, dbgAck;

    int checks = 0;
    int errors = 0;

    inst_fetch_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .DBG_WAIT_MAX(WaitMax)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall),
        .flush_i        (flush),
        .new_pc_i       (newPc),
        .branch_flag_i  (branchFlag),
        .branch_target_i(branchTarget),
        .rom_inst_i     (romInst),
        .rom_ce_o       (romCe),
        .rom_addr_o     (romAddr),
        .if_pc_o        (ifPc),
        .if_inst_o      (ifInst),
        .if_valid_o     (ifValid),
        .dbg_req_i      (dbgReq),
        .dbg_addr_i     (dbgAddr),
        .dbg_ack_o      (dbgAck),
        .dbg_data_o     (dbgData)
    );

    always #5 clk = ~clk;

    // Combinational ROM: word index is the value stored, gated by chip enable.
    assign romInst = romCe ? (romAddr >> 2) : 32'h0;

    // Reference model of the fetch stage as seen at its outputs.
    logic [31:0] mPc, mIfPc, mIfInst, mDbgData, mRomAddr;
    bit          mIfValid, mCe, mAckNow, mIdle, mGrant;
    int          mWaited;

    function automatic logic [31:0] wordOf(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] romRead(input logic [31:0] a, input bit ce);
        return ce ? (a >> 2) : 32'h0;
    endfunction

    task automatic modelReset();
        mPc = 32'h0; mIfPc = 32'h0; mIfInst = 32'h0; mDbgData = 32'h0;
        mIfValid = 1'b0; mCe = 1'b0; mAckNow = 1'b0; mIdle = 1'b1;
        mWaited = 0; mGrant = 1'b0; mRomAddr = 32'h0;
    endtask

    // Decide who owns the ROM in the current cycle.
    task automatic modelDecide();
        mGrant = DbgEn && !mIdle && !mAckNow && dbgReq && !flush &&
                 (stall || (mWaited >= WaitMax));
        mRomAddr = mGrant ? wordOf(dbgAddr) : mPc;
    endtask

    // Apply the rising clock edge to the model.
    task automatic modelAdvance();
        bit wasIdle, wasAck;
        wasIdle = mIdle;
        wasAck  = mAckNow;
        if (mGrant) mDbgData = romRead(mRomAddr, mCe);
        if (wasIdle) begin
        end else if (flush) begin
            mPc = wordOf(newPc);
            mIfValid = 1'b0;
        end else if (mGrant) begin
            if (!stall) mIfValid = 1'b0;
        end else if (!stall) begin
            mIfPc    = mPc;
            mIfInst  = romRead(mPc, mCe);
            mIfValid = 1'b1;
            mPc      = branchFlag ? wordOf(branchTarget) : mPc + 32'd4;
        end
        if (!dbgReq || mGrant) mWaited = 0;
        else if (!wasIdle && !wasAck && mWaited < WaitMax) mWaited++;
        mCe = 1'b1;
        mIdle = 1'b0;
        mAckNow = mGrant;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit st, input bit fl, input logic [31:0] np,
                                 input bit br, input logic [31:0] bt,
                                 input bit rq, input logic [31:0] da);
        stall = st; flush = fl; newPc = np; branchFlag = br;
        branchTarget = bt; dbgReq = rq; dbgAddr = da;
    endtask

    // One clock cycle: check the ROM side mid-cycle, then the registers after the edge.
    task automatic stepCycle();
        #1;
        modelDecide();
        checkOutput("romAddr", romAddr, mRomAddr);
        checkOutput("romCe", 32'(romCe), 32'(mCe));
        @(posedge clk);
        modelAdvance();
        #1;
        checkOutput("ifPc", ifPc, mIfPc);
        checkOutput("ifInst", ifInst, mIfInst);
        checkOutput("ifValid", 32'(ifValid), 32'(mIfValid));
        checkOutput("dbgAck", 32'(dbgAck), 32'(mAckNow));
        checkOutput("dbgData", dbgData, mDbgData);
    endtask

    typedef struct {
        bit          st;
        bit          fl;
        logic [31:0] np;
        bit          br;
        logic [31:0] bt;
        logic [31:0] expPc;
        logic [31:0] expInst;
        bit          expValid;
    } vec_t;

    function automatic vec_t mkVec(bit st, bit fl, logic [31:0] np, bit br, logic [31:0] bt,
                                   logic [31:0] ep, logic [31:0] ei, bit ev);
        vec_t v;
        v.st = st; v.fl = fl; v.np = np; v.br = br; v.bt = bt;
        v.expPc = ep; v.expInst = ei; v.expValid = ev;
        return v;
    endfunction

    vec_t vecs[16];
    int   latency, bubbles, breaks;
    bit   havePrev, prevAck, curAck, reqR;
    logic [31:0] prevPc, addrR;

    task automatic observeStream();
        if (!ifValid) begin
            bubbles++;
        end else begin
            if (havePrev && ifPc !== prevPc + 32'd4) breaks++;
            prevPc = ifPc;
            havePrev = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Expected IF outputs after each cycle, cycle 0 being IDLE.
        vecs[0]  = mkVec(0, 0, 0,         0, 0,         32'h000, 32'h00, 0);
        vecs[1]  = mkVec(0, 0, 0,         0, 0,         32'h000, 32'h00, 1);
        vecs[2]  = mkVec(0, 0, 0,         0, 0,         32'h004, 32'h01, 1);
        vecs[3]  = mkVec(0, 0, 0,         0, 0,         32'h008, 32'h02, 1);
        vecs[4]  = mkVec(0, 0, 0,         0, 0,         32'h00C, 32'h03, 1);
        vecs[5]  = mkVec(0, 0, 0,         0, 0,         32'h010, 32'h04, 1);
        vecs[6]  = mkVec(0, 0, 0,         1, 32'h040,   32'h014, 32'h05, 1);
        vecs[7]  = mkVec(0, 0, 0,         0, 0,         32'h040, 32'h10, 1);
        vecs[8]  = mkVec(1, 0, 0,         0, 0,         32'h040, 32'h10, 1);
        vecs[9]  = mkVec(1, 1, 32'h083,   0, 0,         32'h040, 32'h10, 0);
        vecs[10] = mkVec(0, 0, 0,         0, 0,         32'h080, 32'h20, 1);
        vecs[11] = mkVec(1, 0, 0,         1, 32'h103,   32'h080, 32'h20, 1);
        vecs[12] = mkVec(0, 0, 0,         0, 0,         32'h084, 32'h21, 1);
        vecs[13] = mkVec(0, 1, 32'h200,   1, 32'h300,   32'h084, 32'h21, 0);
        vecs[14] = mkVec(0, 0, 0,         1, 32'h007,   32'h200, 32'h80, 1);
        vecs[15] = mkVec(0, 0, 0,         0, 0,         32'h004, 32'h01, 1);

        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstRomCe", 32'(romCe), 32'h0);
        checkOutput("rstIfValid", 32'(ifValid), 32'h0);
        checkOutput("rstIfPc", ifPc, 32'h0);
        checkOutput("rstIfInst", ifInst, 32'h0);
        checkOutput("rstDbgAck", 32'(dbgAck), 32'h0);
        checkOutput("rstDbgData", dbgData, 32'h0);
        checkOutput("rstRomAddr", romAddr, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].st, vecs[i].fl, vecs[i].np, vecs[i].br, vecs[i].bt, 0, 0);
            stepCycle();
            checkOutput($sformatf("vec%0d.ifPc", i), ifPc, vecs[i].expPc);
            checkOutput($sformatf("vec%0d.ifInst", i), ifInst, vecs[i].expInst);
            checkOutput($sformatf("vec%0d.ifValid", i), 32'(ifValid), 32'(vecs[i].expValid));
        end

        // PC wrap at the top of the address space.
        applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        checkOutput("wrapIfPc", ifPc, 32'hFFFF_FFFC);
        checkOutput("wrapIfInst", ifInst, 32'h3FFF_FFFF);
        checkOutput("wrapRomAddr", romAddr, 32'h0);
        stepCycle();
        checkOutput("wrapNextPc", ifPc, 32'h0);

`ifdef INST_FETCH_DBG_EN
        // Debug read while stalled: served at once, pc untouched.
        applyStimulus(1, 0, 0, 0, 0, 1, 32'h23);
        stepCycle();
        checkOutput("stallDbgAck", 32'(dbgAck), 32'h1);
        checkOutput("stallDbgData", dbgData, 32'h8);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        stepCycle();
        checkOutput("stallDbgAckDone", 32'(dbgAck), 32'h0);
        checkOutput("stallDbgPc", romAddr, 32'h4);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        checkOutput("stallDbgResume", ifPc, 32'h4);

        // Debug read while running: forced after the wait budget, one bubble.
        // Latency counts the rise cycle and the ack cycle inclusively.
        latency = 0; bubbles = 0; breaks = 0; havePrev = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h40);
        for (int k = 1; k <= 30 && latency == 0; k++) begin
            stepCycle();
            observeStream();
            if (dbgAck) latency = k + 1;
        end
        checkOutput("runDbgLatency", 32'(latency), 32'(WaitMax + 2));
        checkOutput("runDbgData", dbgData, 32'h10);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (2) begin
            stepCycle();
            observeStream();
        end
        checkOutput("runDbgBubbles", 32'(bubbles), 32'h1);
        checkOutput("runDbgStream", 32'(breaks), 32'h0);

        // Flush arriving in the ack cycle.
        applyStimulus(1, 0, 0, 0, 0, 1, 32'h8);
        stepCycle();
        checkOutput("flushDbgAck", 32'(dbgAck), 32'h1);
        checkOutput("flushDbgData", dbgData, 32'h2);
        applyStimulus(0, 1, 32'h300, 0, 0, 1, 32'h8);
        stepCycle();
        checkOutput("flushDbgValid", 32'(ifValid), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        checkOutput("flushDbgPc", ifPc, 32'h300);
        checkOutput("flushDbgInst", ifInst, 32'hC0);

        // Reset in the grant cycle drops the request; it is re-served afterwards.
        applyStimulus(1, 0, 0, 0, 0, 1, 32'h44);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rstMidAck", 32'(dbgAck), 32'h0);
        checkOutput("rstMidCe", 32'(romCe), 32'h0);
        checkOutput("rstMidValid", 32'(ifValid), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rstHoldAck", 32'(dbgAck), 32'h0);
        rst_n = 1'b1;
        stepCycle();
        checkOutput("reserveIdleAck", 32'(dbgAck), 32'h0);
        stepCycle();
        checkOutput("reserveAck", 32'(dbgAck), 32'h1);
        checkOutput("reserveData", dbgData, 32'h11);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        stepCycle();
`endif

        // Randomized traffic against the model; the requester holds its
        // request until acked and may re-request right after the ack.
        prevAck = 1'b0;
        reqR = 1'b0;
        addrR = 32'h0;
        for (int n = 0; n < 400; n++) begin
            curAck = mAckNow;
            if (prevAck) begin
                if ($urandom_range(0, 1) == 0) reqR = 1'b0;
                else addrR = 32'($urandom_range(0, 1023));
            end else if (!reqR && $urandom_range(0, 5) == 0) begin
                reqR = 1'b1;
                addrR = 32'($urandom_range(0, 1023));
            end
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom,
                          $urandom_range(0, 5) == 0, $urandom, reqR, addrR);
            stepCycle();
            prevAck = curAck;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
